// File: rtl/sc_statemachine_opseq_pkg.sv
// Shared encodings for the command-driven datapath sequencer:
// FSM states, write-condition codes and the idle-code building blocks.
package sc_statemachine_opseq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_OPER  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [2:0] COND_ALWAYS     = 3'b000;
  localparam logic [2:0] COND_ZERO       = 3'b001;
  localparam logic [2:0] COND_CARRY      = 3'b010;
  localparam logic [2:0] COND_NEGATIVE   = 3'b011;
  localparam logic [2:0] COND_OVERFLOW   = 3'b100;
  localparam logic [2:0] COND_NOT_ZERO   = 3'b101;
  localparam logic [2:0] COND_NEVER      = 3'b110;
  localparam logic [2:0] COND_ALWAYS_ALT = 3'b111;

  // Idle selects are all-ones at any width; replicate this bit to build them.
  localparam logic IDLE_SEL_BIT = 1'b1;
  localparam logic IDLE_LOAD_N  = 1'b1;

endpackage

// File: rtl/sc_statemachine_condeval.sv
// Evaluates a 3-bit write condition against active-high ALU flags.
module sc_statemachine_condeval
  import sc_statemachine_opseq_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       zero,
  input  logic       carry,
  input  logic       negative,
  input  logic       overflow,
  output logic       take_write
);

  always_comb begin
    take_write = 1'b0;
    case (cond)
      COND_ALWAYS:     take_write = 1'b1;
      COND_ZERO:       take_write = zero;
      COND_CARRY:      take_write = carry;
      COND_NEGATIVE:   take_write = negative;
      COND_OVERFLOW:   take_write = overflow;
      COND_NOT_ZERO:   take_write = ~zero;
      COND_NEVER:      take_write = 1'b0;
      COND_ALWAYS_ALT: take_write = 1'b1;
      default:         take_write = 1'b0;
    endcase
  end

endmodule

// File: rtl/sc_statemachine_opseq.sv
// Command-driven micro-sequencer: OPER -> LOAD -> SHIFT* -> WRITE -> DONE,
// driving mux/ALU/shifter/write-decoder selects from a latched command.
module sc_statemachine_opseq
  import sc_statemachine_opseq_pkg::*;
#(
  parameter int DATAWIDTH_DECODER_SELECTION    = 3,
  parameter int DATAWIDTH_MUX_SELECTION        = 3,
  parameter int DATAWIDTH_ALU_SELECTION        = 4,
  parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2,
  parameter int DATAWIDTH_SHIFTCOUNT           = 3
) (
  input  logic                                      SC_STATEMACHINE_CLOCK_50,
  input  logic                                      SC_STATEMACHINE_Reset_InHigh,
  input  logic                                      SC_STATEMACHINE_Start_InHigh,
  input  logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_STATEMACHINE_CmdSrcA_In,
  input  logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_STATEMACHINE_CmdSrcB_In,
  input  logic [DATAWIDTH_ALU_SELECTION-1:0]        SC_STATEMACHINE_CmdALU_In,
  input  logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_STATEMACHINE_CmdShiftDir_In,
  input  logic [DATAWIDTH_SHIFTCOUNT-1:0]           SC_STATEMACHINE_CmdShiftCount_In,
  input  logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_STATEMACHINE_CmdDest_In,
  input  logic [2:0]                                SC_STATEMACHINE_CmdCond_In,
  input  logic                                      SC_STATEMACHINE_Overflow_InLow,
  input  logic                                      SC_STATEMACHINE_Carry_InLow,
  input  logic                                      SC_STATEMACHINE_Negative_InLow,
  input  logic                                      SC_STATEMACHINE_Zero_InLow,
  output logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_STATEMACHINE_DecoderSelectionWrite_Out,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_STATEMACHINE_MUXSelectionBUSA_Out,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_STATEMACHINE_MUXSelectionBUSB_Out,
  output logic [DATAWIDTH_ALU_SELECTION-1:0]        SC_STATEMACHINE_ALUSelection_Out,
  output logic                                      SC_STATEMACHINE_RegSHIFTERLoad_OutLow,
  output logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_STATEMACHINE_RegSHIFTERShiftSelection_OutLow,
  output logic                                      SC_STATEMACHINE_Busy_Out,
  output logic                                      SC_STATEMACHINE_Done_Out,
  output logic                                      SC_STATEMACHINE_CondTaken_Out
);

  localparam logic [DATAWIDTH_DECODER_SELECTION-1:0]    IDLE_DEC   = {DATAWIDTH_DECODER_SELECTION{IDLE_SEL_BIT}};
  localparam logic [DATAWIDTH_MUX_SELECTION-1:0]        IDLE_MUX   = {DATAWIDTH_MUX_SELECTION{IDLE_SEL_BIT}};
  localparam logic [DATAWIDTH_ALU_SELECTION-1:0]        IDLE_ALU   = {DATAWIDTH_ALU_SELECTION{IDLE_SEL_BIT}};
  localparam logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] IDLE_SHIFT = {DATAWIDTH_REGSHIFTER_SELECTION{IDLE_SEL_BIT}};
  localparam logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SHIFT_LEFT  = DATAWIDTH_REGSHIFTER_SELECTION'(1);
  localparam logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SHIFT_RIGHT = DATAWIDTH_REGSHIFTER_SELECTION'(2);
  localparam logic [DATAWIDTH_SHIFTCOUNT-1:0]           CNT_ZERO    = '0;
  localparam logic [DATAWIDTH_SHIFTCOUNT-1:0]           CNT_ONE     = DATAWIDTH_SHIFTCOUNT'(1);

  state_t                                    state;
  logic [DATAWIDTH_MUX_SELECTION-1:0]        cmd_src_a;
  logic [DATAWIDTH_MUX_SELECTION-1:0]        cmd_src_b;
  logic [DATAWIDTH_ALU_SELECTION-1:0]        cmd_alu;
  logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] cmd_dir;
  logic [DATAWIDTH_SHIFTCOUNT-1:0]           cmd_count;
  logic [DATAWIDTH_DECODER_SELECTION-1:0]    cmd_dest;
  logic [2:0]                                cmd_cond;
  logic [DATAWIDTH_SHIFTCOUNT-1:0]           shift_cnt;
  logic flag_z, flag_c, flag_n, flag_v;
  logic eval_z, eval_c, eval_n, eval_v;
  logic take_write;
  logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] shift_code;

  // Outputs are registered, so the WRITE decoder value is decided on the edge
  // entering WRITE; coming from LOAD the flags are being latched that same edge.
  always_comb begin
    eval_z = flag_z;
    eval_c = flag_c;
    eval_n = flag_n;
    eval_v = flag_v;
    if (state == ST_LOAD) begin
      eval_z = ~SC_STATEMACHINE_Zero_InLow;
      eval_c = ~SC_STATEMACHINE_Carry_InLow;
      eval_n = ~SC_STATEMACHINE_Negative_InLow;
      eval_v = ~SC_STATEMACHINE_Overflow_InLow;
    end
  end

  assign shift_code = (cmd_dir == SHIFT_LEFT || cmd_dir == SHIFT_RIGHT) ? cmd_dir : IDLE_SHIFT;

  sc_statemachine_condeval u_condeval (
    .cond       (cmd_cond),
    .zero       (eval_z),
    .carry      (eval_c),
    .negative   (eval_n),
    .overflow   (eval_v),
    .take_write (take_write)
  );

  always_ff @(posedge SC_STATEMACHINE_CLOCK_50 or posedge SC_STATEMACHINE_Reset_InHigh) begin
    if (SC_STATEMACHINE_Reset_InHigh) begin
      state     <= ST_IDLE;
      cmd_src_a <= '0;
      cmd_src_b <= '0;
      cmd_alu   <= '0;
      cmd_dir   <= '0;
      cmd_count <= '0;
      cmd_dest  <= '0;
      cmd_cond  <= '0;
      shift_cnt <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_n    <= 1'b0;
      flag_v    <= 1'b0;
      SC_STATEMACHINE_CondTaken_Out                   <= 1'b0;
      SC_STATEMACHINE_DecoderSelectionWrite_Out       <= IDLE_DEC;
      SC_STATEMACHINE_MUXSelectionBUSA_Out            <= IDLE_MUX;
      SC_STATEMACHINE_MUXSelectionBUSB_Out            <= IDLE_MUX;
      SC_STATEMACHINE_ALUSelection_Out                <= IDLE_ALU;
      SC_STATEMACHINE_RegSHIFTERLoad_OutLow           <= IDLE_LOAD_N;
      SC_STATEMACHINE_RegSHIFTERShiftSelection_OutLow <= IDLE_SHIFT;
      SC_STATEMACHINE_Busy_Out                        <= 1'b0;
      SC_STATEMACHINE_Done_Out                        <= 1'b0;
    end else begin
      // Each branch below describes the outputs of the state being entered.
      SC_STATEMACHINE_DecoderSelectionWrite_Out       <= IDLE_DEC;
      SC_STATEMACHINE_MUXSelectionBUSA_Out            <= IDLE_MUX;
      SC_STATEMACHINE_MUXSelectionBUSB_Out            <= IDLE_MUX;
      SC_STATEMACHINE_ALUSelection_Out                <= IDLE_ALU;
      SC_STATEMACHINE_RegSHIFTERLoad_OutLow           <= IDLE_LOAD_N;
      SC_STATEMACHINE_RegSHIFTERShiftSelection_OutLow <= IDLE_SHIFT;
      SC_STATEMACHINE_Busy_Out                        <= 1'b1;
      SC_STATEMACHINE_Done_Out                        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (SC_STATEMACHINE_Start_InHigh) begin
            cmd_src_a <= SC_STATEMACHINE_CmdSrcA_In;
            cmd_src_b <= SC_STATEMACHINE_CmdSrcB_In;
            cmd_alu   <= SC_STATEMACHINE_CmdALU_In;
            cmd_dir   <= SC_STATEMACHINE_CmdShiftDir_In;
            cmd_count <= SC_STATEMACHINE_CmdShiftCount_In;
            cmd_dest  <= SC_STATEMACHINE_CmdDest_In;
            cmd_cond  <= SC_STATEMACHINE_CmdCond_In;
            state     <= ST_OPER;
            SC_STATEMACHINE_MUXSelectionBUSA_Out <= SC_STATEMACHINE_CmdSrcA_In;
            SC_STATEMACHINE_MUXSelectionBUSB_Out <= SC_STATEMACHINE_CmdSrcB_In;
            SC_STATEMACHINE_ALUSelection_Out     <= SC_STATEMACHINE_CmdALU_In;
          end else begin
            SC_STATEMACHINE_Busy_Out <= 1'b0;
          end
        end
        ST_OPER: begin
          state <= ST_LOAD;
          SC_STATEMACHINE_MUXSelectionBUSA_Out  <= cmd_src_a;
          SC_STATEMACHINE_MUXSelectionBUSB_Out  <= cmd_src_b;
          SC_STATEMACHINE_ALUSelection_Out      <= cmd_alu;
          SC_STATEMACHINE_RegSHIFTERLoad_OutLow <= 1'b0;
        end
        ST_LOAD: begin
          flag_z <= eval_z;
          flag_c <= eval_c;
          flag_n <= eval_n;
          flag_v <= eval_v;
          if (cmd_count == CNT_ZERO) begin
            state <= ST_WRITE;
            SC_STATEMACHINE_DecoderSelectionWrite_Out <= take_write ? cmd_dest : IDLE_DEC;
          end else begin
            state     <= ST_SHIFT;
            shift_cnt <= cmd_count;
            SC_STATEMACHINE_RegSHIFTERShiftSelection_OutLow <= shift_code;
          end
        end
        ST_SHIFT: begin
          shift_cnt <= shift_cnt - CNT_ONE;
          if (shift_cnt == CNT_ONE) begin
            state <= ST_WRITE;
            SC_STATEMACHINE_DecoderSelectionWrite_Out <= take_write ? cmd_dest : IDLE_DEC;
          end else begin
            SC_STATEMACHINE_RegSHIFTERShiftSelection_OutLow <= shift_code;
          end
        end
        ST_WRITE: begin
          state                         <= ST_DONE;
          SC_STATEMACHINE_CondTaken_Out <= take_write;
          SC_STATEMACHINE_Done_Out      <= 1'b1;
        end
        ST_DONE: begin
          state                    <= ST_IDLE;
          SC_STATEMACHINE_Busy_Out <= 1'b0;
        end
        default: begin
          state                    <= ST_IDLE;
          SC_STATEMACHINE_Busy_Out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_statemachine_opseq.sv
// Self-checking bench: per-cycle expected output records are queued when a
// command is issued and popped/compared on every falling clock edge.
module tb_sc_statemachine_opseq;

  typedef struct packed {
    logic [2:0] dec;
    logic [2:0] mux_a;
    logic [2:0] mux_b;
    logic [3:0] alu;
    logic       load_n;
    logic [1:0] shift_sel;
    logic       busy;
    logic       done;
  } outs_t;

  typedef struct {
    string      name;
    logic [2:0] src_a;
    logic [2:0] src_b;
    logic [3:0] alu;
    logic [1:0] dir;
    logic [2:0] count;
    logic [2:0] dest;
    logic [2:0] cond;
    logic [3:0] flags_n;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] src_a, src_b, dest, cond, count;
  logic [3:0] alu;
  logic [1:0] dir;
  logic       ovf_n, carry_n, neg_n, zero_n;
  logic [2:0] dec_out, mux_a_out, mux_b_out;
  logic [3:0] alu_out;
  logic       load_n_out, busy_out, done_out, taken_out;
  logic [1:0] shift_out;

  outs_t q[$];
  logic  expTaken;
  int    checkCount = 0;
  int    passCount  = 0;
  vec_t  vecs[10];
  vec_t  heldA, heldB, longShift;

  always #10 clk = ~clk;

  sc_statemachine_opseq dut (
    .SC_STATEMACHINE_CLOCK_50                        (clk),
    .SC_STATEMACHINE_Reset_InHigh                    (rst),
    .SC_STATEMACHINE_Start_InHigh                    (start),
    .SC_STATEMACHINE_CmdSrcA_In                      (src_a),
    .SC_STATEMACHINE_CmdSrcB_In                      (src_b),
    .SC_STATEMACHINE_CmdALU_In                       (alu),
    .SC_STATEMACHINE_CmdShiftDir_In                  (dir),
    .SC_STATEMACHINE_CmdShiftCount_In                (count),
    .SC_STATEMACHINE_CmdDest_In                      (dest),
    .SC_STATEMACHINE_CmdCond_In                      (cond),
    .SC_STATEMACHINE_Overflow_InLow                  (ovf_n),
    .SC_STATEMACHINE_Carry_InLow                     (carry_n),
    .SC_STATEMACHINE_Negative_InLow                  (neg_n),
    .SC_STATEMACHINE_Zero_InLow                      (zero_n),
    .SC_STATEMACHINE_DecoderSelectionWrite_Out       (dec_out),
    .SC_STATEMACHINE_MUXSelectionBUSA_Out            (mux_a_out),
    .SC_STATEMACHINE_MUXSelectionBUSB_Out            (mux_b_out),
    .SC_STATEMACHINE_ALUSelection_Out                (alu_out),
    .SC_STATEMACHINE_RegSHIFTERLoad_OutLow           (load_n_out),
    .SC_STATEMACHINE_RegSHIFTERShiftSelection_OutLow (shift_out),
    .SC_STATEMACHINE_Busy_Out                        (busy_out),
    .SC_STATEMACHINE_Done_Out                        (done_out),
    .SC_STATEMACHINE_CondTaken_Out                   (taken_out)
  );

  function automatic outs_t idleOuts();
    outs_t o;
    o.dec = 3'b111; o.mux_a = 3'b111; o.mux_b = 3'b111; o.alu = 4'b1111;
    o.load_n = 1'b1; o.shift_sel = 2'b11; o.busy = 1'b0; o.done = 1'b0;
    return o;
  endfunction

  function automatic outs_t sampleOutputs();
    outs_t o;
    o.dec = dec_out; o.mux_a = mux_a_out; o.mux_b = mux_b_out; o.alu = alu_out;
    o.load_n = load_n_out; o.shift_sel = shift_out; o.busy = busy_out; o.done = done_out;
    return o;
  endfunction

  // Reference truth table for the write condition; flags_n = {V,C,N,Z}, active low.
  function automatic logic modelTake(input logic [2:0] c, input logic [3:0] fn);
    case (c)
      3'b000:  return 1'b1;
      3'b001:  return ~fn[0];
      3'b010:  return ~fn[2];
      3'b011:  return ~fn[1];
      3'b100:  return ~fn[3];
      3'b101:  return fn[0];
      3'b110:  return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic checkOutput(input string name);
    outs_t e;
    if (q.size() == 0) begin
      checkCount++;
      $display("[TB] FAIL %s: got empty scoreboard, expected a queued record", name);
    end else begin
      e = q.pop_front();
      checkValue(name, 32'(sampleOutputs()), 32'(e));
    end
  endtask

  task automatic driveCmd(input vec_t v);
    src_a = v.src_a; src_b = v.src_b; alu = v.alu; dir = v.dir; count = v.count;
    dest = v.dest; cond = v.cond;
    {ovf_n, carry_n, neg_n, zero_n} = v.flags_n;
  endtask

  task automatic pushExpected(input vec_t v);
    outs_t o;
    o = idleOuts(); o.busy = 1'b1; o.mux_a = v.src_a; o.mux_b = v.src_b; o.alu = v.alu;
    q.push_back(o);
    o.load_n = 1'b0;
    q.push_back(o);
    o = idleOuts(); o.busy = 1'b1;
    o.shift_sel = (v.dir == 2'b01 || v.dir == 2'b10) ? v.dir : 2'b11;
    for (int i = 0; i < int'(v.count); i++) q.push_back(o);
    o = idleOuts(); o.busy = 1'b1;
    o.dec = modelTake(v.cond, v.flags_n) ? v.dest : 3'b111;
    q.push_back(o);
    o = idleOuts(); o.busy = 1'b1; o.done = 1'b1;
    q.push_back(o);
    q.push_back(idleOuts());
    expTaken = modelTake(v.cond, v.flags_n);
  endtask

  task automatic applyStimulus(input vec_t v);
    driveCmd(v);
    start = 1'b1;
    pushExpected(v);
  endtask

  task automatic stepAndCheck(input int n, input logic dropStart, input string name);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (dropStart) start = 1'b0;
      checkOutput($sformatf("%s_c%0d", name, i + 1));
    end
  endtask

  task automatic runCommand(input vec_t v);
    @(negedge clk);
    applyStimulus(v);
    stepAndCheck(q.size(), 1'b1, v.name);
    checkValue({v.name, "_taken"}, 32'(taken_out), 32'(expTaken));
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{"add_basic",   3'd4, 3'd5, 4'd8,  2'b00, 3'd0, 3'd3, 3'b000, 4'b1111};
    vecs[1] = '{"shift_left3", 3'd1, 3'd2, 4'd3,  2'b01, 3'd3, 3'd2, 3'b000, 4'b1111};
    vecs[2] = '{"cond_z_false",3'd0, 3'd6, 4'd2,  2'b10, 3'd0, 3'd4, 3'b001, 4'b1111};
    vecs[3] = '{"cond_z_true", 3'd3, 3'd1, 4'd5,  2'b10, 3'd2, 3'd5, 3'b001, 4'b1110};
    vecs[4] = '{"cond_c_true", 3'd2, 3'd3, 4'd1,  2'b00, 3'd0, 3'd1, 3'b010, 4'b1011};
    vecs[5] = '{"cond_n_false",3'd6, 3'd0, 4'd7,  2'b01, 3'd1, 3'd6, 3'b011, 4'b1111};
    vecs[6] = '{"cond_v_hold", 3'd5, 3'd4, 4'd9,  2'b00, 3'd2, 3'd0, 3'b100, 4'b0111};
    vecs[7] = '{"cond_nz_dir3",3'd1, 3'd1, 4'd4,  2'b11, 3'd1, 3'd2, 3'b101, 4'b1111};
    vecs[8] = '{"cond_never",  3'd0, 3'd0, 4'd0,  2'b01, 3'd7, 3'd3, 3'b110, 4'b0000};
    vecs[9] = '{"dest_none",   3'd2, 3'd5, 4'd14, 2'b10, 3'd0, 3'd7, 3'b111, 4'b1111};
    heldA     = '{"held_first",  3'd3, 3'd4, 4'd6, 2'b01, 3'd1, 3'd2, 3'b000, 4'b1111};
    heldB     = '{"held_second", 3'd6, 3'd2, 4'd11,2'b10, 3'd2, 3'd5, 3'b000, 4'b1111};
    longShift = '{"reset_mid",   3'd1, 3'd6, 4'd2, 2'b01, 3'd5, 3'd4, 3'b000, 4'b1111};

    rst = 1'b1;
    start = 1'b0;
    driveCmd(vecs[0]);
    repeat (2) @(negedge clk);
    checkValue("reset_outputs", 32'(sampleOutputs()), 32'(idleOuts()));
    checkValue("reset_taken", 32'(taken_out), 32'h0);
    rst = 1'b0;
    q.push_back(idleOuts());
    stepAndCheck(1, 1'b1, "post_reset_idle");

    foreach (vecs[i]) runCommand(vecs[i]);

    // Start held high: one command per IDLE visit, latch frozen while busy.
    @(negedge clk);
    applyStimulus(heldA);
    stepAndCheck(1, 1'b0, "held_first");
    driveCmd(heldB);
    stepAndCheck(q.size(), 1'b0, "held_first_rest");
    checkValue("held_first_taken", 32'(taken_out), 32'(expTaken));
    pushExpected(heldB);
    stepAndCheck(q.size(), 1'b1, "held_second");

    // Reset during SHIFT: asynchronous return to idle, no WRITE, no Done.
    runCommand(vecs[0]);
    @(negedge clk);
    applyStimulus(longShift);
    stepAndCheck(4, 1'b1, "reset_mid_pre");
    rst = 1'b1;
    #1;
    checkValue("reset_mid_async", 32'(sampleOutputs()), 32'(idleOuts()));
    checkValue("reset_mid_taken", 32'(taken_out), 32'h0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) q.push_back(idleOuts());
    stepAndCheck(6, 1'b1, "reset_mid_after");
    runCommand(vecs[1]);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/sc_statemachine_opseq.md
Name: sc_statemachine_opseq

Overview:
- Parametrised, command-driven successor to the fixed single-ADD sequencer.
- Accepts one datapath command per start pulse: source A, source B, ALU op, shift direction and count, destination, write condition.
- Sequences the register-bank muxes, ALU, shift register and write decoder through a multi-cycle micro-sequence, then reports completion.
- Sits between a future instruction decoder and the existing register bank / ALU / shifter datapath.

Parameters:
- DATAWIDTH_DECODER_SELECTION, 3, width of destination write-decoder select; all-ones = no register written
- DATAWIDTH_MUX_SELECTION, 3, width of BUSA/BUSB mux select; all-ones = idle code
- DATAWIDTH_ALU_SELECTION, 4, width of ALU op select; all-ones = idle code
- DATAWIDTH_REGSHIFTER_SELECTION, 2, width of shift select (01 left, 10 right, 00/11 hold)
- DATAWIDTH_SHIFTCOUNT, 3, width of shift-count field; 0..2^W-1 shift cycles

Ports:
- SC_STATEMACHINE_CLOCK_50  in  1  single clock
- SC_STATEMACHINE_Reset_InHigh  in  1  asynchronous, active-high reset
- SC_STATEMACHINE_Start_InHigh  in  1  command strobe; sampled only in IDLE
- SC_STATEMACHINE_CmdSrcA_In  in  MUX  BUSA select for the command
- SC_STATEMACHINE_CmdSrcB_In  in  MUX  BUSB select
- SC_STATEMACHINE_CmdALU_In  in  ALU  ALU op
- SC_STATEMACHINE_CmdShiftDir_In  in  REGSHIFTER  shift direction
- SC_STATEMACHINE_CmdShiftCount_In  in  SHIFTCOUNT  number of shift cycles
- SC_STATEMACHINE_CmdDest_In  in  DECODER  destination register
- SC_STATEMACHINE_CmdCond_In  in  3  write condition: 000 always, 001 Z, 010 C, 011 N, 100 V, 101 not Z, 110 never, 111 always
- SC_STATEMACHINE_Overflow_InLow / _Carry_InLow / _Negative_InLow / _Zero_InLow  in  1 each  ALU flags, active low
- SC_STATEMACHINE_DecoderSelectionWrite_Out  out  DECODER  register write select
- SC_STATEMACHINE_MUXSelectionBUSA_Out / _MUXSelectionBUSB_Out  out  MUX  bus selects
- SC_STATEMACHINE_ALUSelection_Out  out  ALU  ALU op
- SC_STATEMACHINE_RegSHIFTERLoad_OutLow  out  1  shifter load, active low
- SC_STATEMACHINE_RegSHIFTERShiftSelection_OutLow  out  REGSHIFTER  shift control
- SC_STATEMACHINE_Busy_Out  out  1  high in every non-IDLE state
- SC_STATEMACHINE_Done_Out  out  1  one-cycle completion pulse
- SC_STATEMACHINE_CondTaken_Out  out  1  registered; 1 = last command wrote its destination

Behaviour:
- Reset and interface
  - Reset is asynchronous and active-high. It forces IDLE, clears the command latch, shift counter and flag latch, and sets CondTaken_Out=0.
  - All datapath outputs are Moore (decoded from state plus latched command).
  - Idle output set: decoder all-ones, both muxes all-ones, ALU all-ones, Load=1, ShiftSel=2'b11, Busy=0, Done=0.
- States
  - IDLE: idle set. If Start=1 at a clock edge, latch all Cmd* fields, then go to OPER.
  - OPER: mux A/B and ALU from the latch; remaining outputs idle; then go to LOAD.
  - LOAD: same as OPER plus Load=0. At exit, latch the four flags inverted to active-high. If count=0 go to WRITE, else go to SHIFT and set counter=count.
  - SHIFT: mux/ALU idle, Load=1, ShiftSel=latched dir. Counter decrements each cycle; exit to WRITE after the cycle in which counter==1.
  - WRITE: decoder=latched dest if the condition is true on the latched flags, else all-ones. CondTaken_Out is registered at exit. Then go to DONE.
  - DONE: idle set except Busy=1, Done=1. Then go to IDLE.
- Timing
  - Latency from Start edge to Done high: 4+count cycles.
  - Next Start is accepted on the cycle after DONE.
- Boundary cases
  - Start while Busy is ignored, and the command latch stays stable.
  - Dest all-ones: no write; CondTaken still reflects condition evaluation.
  - Direction 00/11 with count>0: the cycles still elapse with ShiftSel=11.
  - Reset mid-sequence: outputs return to the idle set immediately (asynchronously); no WRITE and no Done.
  - Undefined state encoding returns to IDLE with the idle set.

Decomposition:
- Package sc_statemachine_opseq_pkg holds:
  - state encodings
  - condition codes
  - idle-code localparams (all-ones selects, Load=1, ShiftSel=11)
- One sub-module, sc_statemachine_condeval: combinational. Inputs are the 3-bit condition and 4 active-high flags; output is take_write.

Test Plan:
- Reset, then Start with A=100, B=101, ALU=1000, count=0, dest=011, cond=000:
  - cycle-exact sequence: OPER, then LOAD (Load=0), then WRITE (decoder=011), then Done at cycle 4
  - CondTaken=1
- Count=3, dir=01: three SHIFT cycles with ShiftSel=01 and Load=1; WRITE at cycle 6, Done at cycle 7.
- cond=001 with Zero_InLow=1 during LOAD: WRITE shows decoder=111, CondTaken=0. Repeat with Zero_InLow=0: decoder=dest, CondTaken=1.
- Start pulses held high through a sequence: exactly one command is executed per IDLE visit; the latch is unchanged while Busy.
- Reset asserted during SHIFT (count=5): outputs immediately return to the idle set; Busy=0; no Done; next Start runs normally.
- dest=111, cond=111: no register write, Done still pulses, CondTaken=1.
